// File: rtl/rf_writeback.sv
// rf_writeback: merges load responses and ALU results into the register
// file's single write port. Loads always win; ALU results wait in a small
// in-order FIFO and are squashed if a younger load targets the same register.
module rf_writeback #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic        RegWrite,
  output logic [4:0]  WriteNum,
  output logic [31:0] WriteData,
  output logic        ld_err,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // FIFO storage: payload arrays plus a per-entry live flag for squashing
  logic [4:0]            rd_mem   [FIFO_DEPTH];
  logic [31:0]           data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_reg;
  logic [PTR_W-1:0]      head_reg;
  logic [PTR_W-1:0]      tail_reg;
  logic [PTR_W:0]        count_reg;

  logic        fifo_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        squash;
  logic        sel_write;
  logic [4:0]  sel_num;
  logic [31:0] sel_data;
  logic        ld_legal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign fifo_empty = (count_reg == '0);
  assign busy       = !fifo_empty;
  // Readiness depends only on stored state, never on ld_valid
  assign alu_ready  = RST && (count_reg < (PTR_W+1)'(FIFO_DEPTH));
  assign accept     = alu_valid && alu_ready;

  // Byte/half lane selection and sign/zero extension of the load word
  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = 16'h0000;
    ld_ext   = 32'h0;
    ld_legal = 1'b1;
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd2:    ld_ext = ld_rdata;
      3'd4:    ld_ext = {24'h0, ld_byte};
      3'd5:    ld_ext = {16'h0, ld_half};
      default: ld_legal = 1'b0;
    endcase
  end

  // Arbitration: load first, then FIFO head, then direct ALU bypass
  always_comb begin
    sel_write = 1'b0;
    sel_num   = 5'd0;
    sel_data  = 32'h0;
    push      = 1'b0;
    pop       = 1'b0;
    squash    = 1'b0;
    if (ld_valid) begin
      sel_write = ld_legal && (ld_rd != 5'd0);
      sel_num   = ld_rd;
      sel_data  = ld_ext;
      push      = accept;
      squash    = (ld_rd != 5'd0);
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      sel_write = live_reg[head_reg] && (rd_mem[head_reg] != 5'd0);
      sel_num   = rd_mem[head_reg];
      sel_data  = data_mem[head_reg];
      push      = accept;
    end else if (accept) begin
      sel_write = (alu_rd != 5'd0);
      sel_num   = alu_rd;
      sel_data  = alu_data;
    end
  end

  // FIFO payload write at the tail; contents are qualified by count/live
  always_ff @(posedge CLK) begin
    if (push) begin
      rd_mem[tail_reg]   <= alu_rd;
      data_mem[tail_reg] <= alu_data;
    end
  end

  // Per-entry live flags: a push marks live, an older-entry squash clears.
  // The push wins so a same-cycle ALU result is never squashed by its load.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_live
      always_ff @(posedge CLK) begin
        if (!RST) begin
          live_reg[gi] <= 1'b0;
        end else if (push && (tail_reg == PTR_W'(gi))) begin
          live_reg[gi] <= 1'b1;
        end else if (squash && (rd_mem[gi] == ld_rd)) begin
          live_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (!RST) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Registered write port; index/data hold whenever no write is issued
  always_ff @(posedge CLK) begin
    if (!RST) begin
      RegWrite  <= 1'b0;
      WriteNum  <= 5'd0;
      WriteData <= 32'h0;
      ld_err    <= 1'b0;
    end else begin
      RegWrite <= sel_write;
      ld_err   <= ld_valid && !ld_legal;
      if (sel_write) begin
        WriteNum  <= sel_num;
        WriteData <= sel_data;
      end
    end
  end

endmodule
